// File: rtl/cdb_arbiter.sv
// Common-data-bus transmitter: per-FU result FIFOs feeding a round-robin
// arbiter whose winner is broadcast on a registered CDB with a matching ack.
package cpu_types;
  typedef logic [3:0] RS_tag_type;
  localparam RS_tag_type INVALID = 4'd0;
  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_t;
endpackage

module cdb_arbiter
  import cpu_types::*;
#(
  parameter int N_FU  = 4,
  parameter int DEPTH = 2
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               FLUSH,
  input  logic [N_FU-1:0]                    fu_valid,
  input  RS_tag_type                         fu_tag  [N_FU],
  input  logic [31:0]                        fu_data [N_FU],
  output logic [N_FU-1:0]                    fu_ready,
  output logic [N_FU-1:0]                    fu_ack,
  output cdb_t                               cdb_out,
  output logic [$clog2(N_FU*DEPTH+1)-1:0]    pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(N_FU);
  localparam int SW = $clog2(N_FU * DEPTH + 1);

  cdb_t            mem_q [N_FU][DEPTH];
  logic [AW-1:0]   rd_q  [N_FU];
  logic [AW-1:0]   rd_d  [N_FU];
  logic [AW-1:0]   wr_q  [N_FU];
  logic [AW-1:0]   wr_d  [N_FU];
  logic [CW-1:0]   cnt_q [N_FU];
  logic [CW-1:0]   cnt_d [N_FU];
  logic [PW-1:0]   rr_q, rr_d;
  cdb_t            cdb_q, cdb_d;
  logic [N_FU-1:0] ack_q, ack_d;
  logic [SW-1:0]   pend_q, pend_d;
  logic [N_FU-1:0] push, pop;
  logic            have_win;
  logic [PW-1:0]   win, cand;
  int              scan_idx;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Round-robin scan over FIFO heads starting at rr_q
  always_comb begin
    have_win = 1'b0;
    win      = rr_q;
    cand     = rr_q;
    scan_idx = 0;
    for (int k = 0; k < N_FU; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= N_FU) scan_idx = scan_idx - N_FU;
      cand = PW'(scan_idx);
      if (!have_win && cnt_q[cand] != '0) begin
        have_win = 1'b1;
        win      = cand;
      end
    end
  end

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < N_FU; i++) begin
      // Ready deliberately ignores a same-cycle pop
      fu_ready[i] = (cnt_q[i] < CW'(DEPTH));
      push[i]     = fu_valid[i] && fu_ready[i] && (fu_tag[i] != INVALID) && !FLUSH;
      pop[i]      = have_win && (win == PW'(i)) && !FLUSH;
      rd_d[i]     = rd_q[i];
      wr_d[i]     = wr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (FLUSH) begin
        rd_d[i]  = '0;
        wr_d[i]  = '0;
        cnt_d[i] = '0;
      end else begin
        if (push[i]) wr_d[i] = ptr_inc(wr_q[i]);
        if (pop[i])  rd_d[i] = ptr_inc(rd_q[i]);
        case ({push[i], pop[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
      pend_d = pend_d + SW'(cnt_d[i]);
    end

    cdb_d.tag  = INVALID;
    cdb_d.data = '0;
    ack_d      = '0;
    rr_d       = rr_q;
    if (!FLUSH && have_win) begin
      cdb_d      = mem_q[win][rd_q[win]];
      ack_d[win] = 1'b1;
      rr_d       = (win == PW'(N_FU - 1)) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < N_FU; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      rr_q       <= '0;
      cdb_q.tag  <= INVALID;
      cdb_q.data <= '0;
      ack_q      <= '0;
      pend_q     <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        rd_q[i]  <= rd_d[i];
        wr_q[i]  <= wr_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      rr_q   <= rr_d;
      cdb_q  <= cdb_d;
      ack_q  <= ack_d;
      pend_q <= pend_d;
    end
  end

  // Storage needs no reset: counts gate every read
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_FU; i++) begin
      if (push[i]) begin
        mem_q[i][wr_q[i]].tag  <= fu_tag[i];
        mem_q[i][wr_q[i]].data <= fu_data[i];
      end
    end
  end

  assign cdb_out = cdb_q;
  assign fu_ack  = ack_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (N_FU=4, DEPTH=2): vector table plus
// hand-written latency and streaming sequences.
module tb_cdb_arbiter;
  import cpu_types::*;

  localparam int N_FU  = 4;
  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        FLUSH;
  logic [3:0]  fu_valid;
  RS_tag_type  fu_tag  [N_FU];
  logic [31:0] fu_data [N_FU];
  logic [3:0]  fu_ready;
  logic [3:0]  fu_ack;
  cdb_t        cdb_out;
  logic [3:0]  pending;

  cdb_arbiter #(.N_FU(N_FU), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .FLUSH   (FLUSH),
    .fu_valid(fu_valid),
    .fu_tag  (fu_tag),
    .fu_data (fu_data),
    .fu_ready(fu_ready),
    .fu_ack  (fu_ack),
    .cdb_out (cdb_out),
    .pending (pending)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic             rst_n;
    logic             flush;
    logic [3:0]       valid;
    logic [3:0][3:0]  tag;
    logic [3:0][31:0] data;
    logic [3:0]       e_ready;
    logic [3:0]       e_ack;
    logic [3:0]       e_tag;
    logic [31:0]      e_data;
    logic [3:0]       e_pend;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic vec(input logic rst_n, input logic flush, input logic [3:0] valid,
                     input logic [15:0] tags, input logic [127:0] data,
                     input logic [3:0] e_ready, input logic [3:0] e_ack,
                     input logic [3:0] e_tag, input logic [31:0] e_data,
                     input logic [3:0] e_pend);
    vec_t v;
    v.rst_n = rst_n; v.flush = flush; v.valid = valid;
    v.tag = tags; v.data = data;
    v.e_ready = e_ready; v.e_ack = e_ack; v.e_tag = e_tag;
    v.e_data = e_data; v.e_pend = e_pend;
    vq.push_back(v);
  endtask

  task automatic idle(input logic [3:0] e_ready, input logic [3:0] e_ack,
                      input logic [3:0] e_tag, input logic [31:0] e_data,
                      input logic [3:0] e_pend);
    vec(1'b1, 1'b0, 4'b0000, 16'h0, 128'h0, e_ready, e_ack, e_tag, e_data, e_pend);
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int          waited;
    int          cyc;
    logic [31:0] got_d[$];
    int          got_c[$];

    RST_N = 1'b0; FLUSH = 1'b0; fu_valid = '0;
    for (int i = 0; i < N_FU; i++) begin fu_tag[i] = '0; fu_data[i] = '0; end

    // Reset held two cycles with every FU offering
    vec(0, 0, 4'hF, 16'h4321, {4{32'h55}}, 4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    vec(0, 0, 4'hF, 16'h4321, {4{32'h55}}, 4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    idle(4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    // Single result from FU2
    vec(1, 0, 4'b0100, 16'h0500, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0},
        4'hF, 4'h0, 4'h0, 32'h0, 4'd1);
    idle(4'hF, 4'b0100, 4'h5, 32'hDEADBEEF, 4'd0);
    idle(4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    // FU3 alone, leaves rr at 0
    vec(1, 0, 4'b1000, 16'h6000, {32'h33, 32'h0, 32'h0, 32'h0},
        4'hF, 4'h0, 4'h0, 32'h0, 4'd1);
    idle(4'hF, 4'b1000, 4'h6, 32'h33, 4'd0);
    // Round-robin over all four
    vec(1, 0, 4'hF, 16'h4321, {32'h13, 32'h12, 32'h11, 32'h10},
        4'hF, 4'h0, 4'h0, 32'h0, 4'd4);
    idle(4'hF, 4'b0001, 4'h1, 32'h10, 4'd3);
    idle(4'hF, 4'b0010, 4'h2, 32'h11, 4'd2);
    idle(4'hF, 4'b0100, 4'h3, 32'h12, 4'd1);
    idle(4'hF, 4'b1000, 4'h4, 32'h13, 4'd0);
    vec(1, 0, 4'b1010, 16'h8070, {32'h23, 32'h0, 32'h21, 32'h0},
        4'hF, 4'h0, 4'h0, 32'h0, 4'd2);
    idle(4'hF, 4'b0010, 4'h7, 32'h21, 4'd1);
    idle(4'hF, 4'b1000, 4'h8, 32'h23, 4'd0);
    // INVALID tag is dropped
    vec(1, 0, 4'b0010, 16'h0000, {32'h0, 32'h0, 32'h5, 32'h0},
        4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    idle(4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    // Back-pressure: FU0 offers 1..5, FU1 keeps its FIFO busy
    vec(1, 0, 4'b0011, 16'h00A9, {32'h0, 32'h0, 32'h101, 32'h1}, 4'hF,    4'h0,    4'h0, 32'h0,   4'd2);
    vec(1, 0, 4'b0011, 16'h00A9, {32'h0, 32'h0, 32'h102, 32'h2}, 4'b1101, 4'b0001, 4'h9, 32'h1,   4'd3);
    vec(1, 0, 4'b0011, 16'h00A9, {32'h0, 32'h0, 32'h103, 32'h3}, 4'b1110, 4'b0010, 4'hA, 32'h101, 4'd3);
    vec(1, 0, 4'b0011, 16'h00A9, {32'h0, 32'h0, 32'h103, 32'h4}, 4'b1101, 4'b0001, 4'h9, 32'h2,   4'd3);
    vec(1, 0, 4'b0011, 16'h00A9, {32'h0, 32'h0, 32'h104, 32'h4}, 4'b1110, 4'b0010, 4'hA, 32'h102, 4'd3);
    vec(1, 0, 4'b0011, 16'h00A9, {32'h0, 32'h0, 32'h104, 32'h5}, 4'b1101, 4'b0001, 4'h9, 32'h3,   4'd3);
    vec(1, 0, 4'b0011, 16'h00A9, {32'h0, 32'h0, 32'h105, 32'h5}, 4'b1110, 4'b0010, 4'hA, 32'h103, 4'd3);
    idle(4'hF, 4'b0001, 4'h9, 32'h4,   4'd2);
    idle(4'hF, 4'b0010, 4'hA, 32'h104, 4'd1);
    idle(4'hF, 4'b0001, 4'h9, 32'h5,   4'd0);
    idle(4'hF, 4'h0,    4'h0, 32'h0,   4'd0);
    // FLUSH with pending=5 and a concurrent FU3 push; rr (=2) must survive
    vec(1, 0, 4'hF, 16'h4321, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 4'h0, 4'h0, 32'h0, 4'd4);
    vec(1, 0, 4'b0101, 16'h0301, {32'h0, 32'hB2, 32'h0, 32'hB0}, 4'b1010, 4'b0010, 4'h2, 32'hA1, 4'd5);
    vec(1, 1, 4'b1000, 16'h4000, {32'hC3, 32'h0, 32'h0, 32'h0}, 4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    idle(4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    idle(4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    vec(1, 0, 4'b0101, 16'h0605, {32'h0, 32'hD2, 32'h0, 32'hD0}, 4'hF, 4'h0, 4'h0, 32'h0, 4'd2);
    idle(4'hF, 4'b0100, 4'h6, 32'hD2, 4'd1);
    idle(4'hF, 4'b0001, 4'h5, 32'hD0, 4'd0);
    // Reset mid-stream discards an unbroadcast result
    vec(1, 0, 4'b0010, 16'h0070, {32'h0, 32'h0, 32'hE1, 32'h0}, 4'hF, 4'h0, 4'h0, 32'h0, 4'd1);
    vec(0, 0, 4'b0000, 16'h0, 128'h0, 4'hF, 4'h0, 4'h0, 32'h0, 4'd0);
    idle(4'hF, 4'h0, 4'h0, 32'h0, 4'd0);

    for (int k = 0; k < vq.size(); k++) begin
      RST_N    = vq[k].rst_n;
      FLUSH    = vq[k].flush;
      fu_valid = vq[k].valid;
      for (int i = 0; i < N_FU; i++) begin
        fu_tag[i]  = vq[k].tag[i];
        fu_data[i] = vq[k].data[i];
      end
      @(posedge CLK); #1;
      chk("ready",   k, {28'h0, fu_ready},    {28'h0, vq[k].e_ready});
      chk("ack",     k, {28'h0, fu_ack},      {28'h0, vq[k].e_ack});
      chk("cdb_tag", k, {28'h0, cdb_out.tag}, {28'h0, vq[k].e_tag});
      chk("cdb_data",k, cdb_out.data,         vq[k].e_data);
      chk("pending", k, {28'h0, pending},     {28'h0, vq[k].e_pend});
    end

    // Latency: accepted at one edge, broadcast at the next
    RST_N = 1'b1; FLUSH = 1'b0;
    fu_valid = 4'b0100; fu_tag[2] = 4'hC; fu_data[2] = 32'h12345678;
    @(posedge CLK); #1;
    fu_valid = '0;
    chk("lat_pend", 0, {28'h0, pending}, 32'd1);
    chk("lat_noack", 0, {28'h0, fu_ack}, 32'd0);
    waited = 0;
    while (fu_ack[2] !== 1'b1 && waited < 8) begin
      @(posedge CLK); #1;
      waited++;
    end
    chk("lat_cycles", 0, waited, 1);
    chk("lat_ack", 0, {28'h0, fu_ack}, 32'h4);
    chk("lat_tag", 0, {28'h0, cdb_out.tag}, 32'hC);
    chk("lat_data", 0, cdb_out.data, 32'h12345678);
    @(posedge CLK); #1;
    chk("pulse_ack", 0, {28'h0, fu_ack}, 32'd0);
    chk("pulse_tag", 0, {28'h0, cdb_out.tag}, {28'h0, INVALID});

    // Single FU streaming back-to-back: order kept, one result per cycle
    cyc = 0;
    for (int j = 0; j < 3; j++) begin
      fu_valid = 4'b1000; fu_tag[3] = 4'hD; fu_data[3] = 32'hF00 + j;
      chk("stream_ready", j, {31'h0, fu_ready[3]}, 32'd1);
      @(posedge CLK); #1;
      cyc++;
      if (fu_ack[3] === 1'b1) begin got_d.push_back(cdb_out.data); got_c.push_back(cyc); end
    end
    fu_valid = '0;
    for (int j = 0; j < 4; j++) begin
      @(posedge CLK); #1;
      cyc++;
      if (fu_ack[3] === 1'b1) begin got_d.push_back(cdb_out.data); got_c.push_back(cyc); end
    end
    chk("stream_count", 0, got_d.size(), 3);
    for (int j = 0; j < 3; j++) begin
      chk("stream_data",  j, (j < got_d.size()) ? got_d[j] : 32'hFFFF_FFFF, 32'hF00 + j);
      chk("stream_cycle", j, (j < got_c.size()) ? got_c[j] : -1, j + 2);
    end
    chk("stream_pend", 0, {28'h0, pending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Transmitter end of the common data bus (CDB). Collects completed results (tag-value pairs) from N_FU functional units, buffers them in a small per-FU FIFO, and selects one per cycle by round-robin. The winner is broadcast on the registered `cdb_out` bus that every reservation station, the map table and the register file snoop. Each FU receives a ready/valid handshake and a per-result acknowledge pulse when its result goes on the bus.

## Interface
Parameters:
- `N_FU`, default 4: number of functional-unit result ports, 2..8.
- `DEPTH`, default 2: entries in each per-FU result FIFO, 1..4.

Ports:
- `CLK`, input, 1: single clock; all state updates on the rising edge.
- `RST_N`, input, 1: synchronous, active-low reset.
- `FLUSH`, input, 1: synchronous squash of all buffered and pending results.
- `fu_valid`, input, [N_FU-1:0]: FU i is offering a result this cycle.
- `fu_tag`, input, RS_tag_type [N_FU]: tag of the producing reservation station, from cpu_types.
- `fu_data`, input, [N_FU][31:0]: result value.
- `fu_ready`, output, [N_FU-1:0]: FIFO i can accept this cycle.
- `fu_ack`, output, [N_FU-1:0]: one-cycle pulse, high in the same cycle that FU i's result is on `cdb_out`.
- `cdb_out`, output, cdb_t: broadcast tag/data. `tag == INVALID` means no broadcast this cycle.
- `pending`, output, [$clog2(N_FU*DEPTH+1)-1:0]: total buffered entries across all FIFOs.

## Operation
- **Push.** FIFO i pushes `{fu_tag[i], fu_data[i]}` at the edge when `fu_valid[i] && fu_ready[i] && fu_tag[i] != INVALID`.
  - A valid with tag INVALID is silently dropped. No push, no ack.
- **Ready.** `fu_ready[i] = (count_i < DEPTH)`. It is not pop-aware, so a full FIFO takes no push even in a cycle when it is popped.
- **Arbitration** (combinational, on FIFO heads):
  - Scan i = rr_ptr, rr_ptr+1, ... mod N_FU; the first non-empty FIFO wins.
  - The winner pops at the edge.
  - Registered outputs at that edge: `cdb_out <= head`, `fu_ack[win] <= 1`, all other acks 0.
  - `rr_ptr <= (win+1) mod N_FU`.
- **No winner.** `cdb_out.tag <= INVALID`, `cdb_out.data <= 0`, acks 0, `rr_ptr` unchanged.
- **FIFO mechanics.**
  - Each FIFO has a circular buffer with read and write pointers wrapping mod DEPTH, plus `count_i` in 0..DEPTH.
  - Push and pop in the same cycle leave the count unchanged and preserve order.
  - Entries from one FU are broadcast strictly in push order.
- **Pending.** `pending` is the registered sum of all `count_i`, updated on every edge.
- **FLUSH** (when `RST_N` = 1), at the next edge:
  - all counts and pointers go to 0;
  - `cdb_out.tag <= INVALID`, all acks 0;
  - pushes in that cycle are discarded;
  - `rr_ptr` is held.
- **Priority:** reset > FLUSH > normal operation.

## Timing
- **Reset values** (edge with `RST_N` = 0):
  - `cdb_out.tag` = INVALID, `cdb_out.data` = 0;
  - `fu_ack` = 0, `pending` = 0;
  - all counts and pointers = 0, `rr_ptr` = 0;
  - `fu_ready` = all ones from the following cycle (combinational from counts).
- **Latency.** A result pushed at edge E0 is eligible in the cycle after E0. Best case it is on `cdb_out` after edge E0+1, so it is visible one cycle after acceptance. There is no same-cycle FU-to-CDB bypass.
- **Worst case** for a head entry is N_FU-1 cycles of waiting plus 1.
- **Throughput.** Exactly one broadcast per cycle while `pending` > 0. A single active FU sustains 1 result/cycle only if DEPTH ≥ 2; with DEPTH = 1 the non-pop-aware ready limits it to one result every 2 cycles.
- `cdb_out` and `fu_ack` are held for exactly one cycle per result; consumers must capture in that cycle.
- **Reset or FLUSH mid-stream:** any result not yet broadcast is lost, with no ack. A broadcast registered at the flushing edge is replaced by INVALID.

## Test plan
- **Reset.** Hold `RST_N`=0 for 2 cycles with `fu_valid`=4'b1111 → `cdb_out.tag`=INVALID, `pending`=0, no ack. Release → `fu_ready`=4'b1111.
- **Single result.** FU2 pushes (T_a, 32'hDEADBEEF) at edge 0, nothing else active → `cdb_out`={T_a, DEADBEEF} and `fu_ack`=4'b0100 in cycle 1 only. INVALID in cycle 2.
- **Round-robin fairness.**
  - Setup: all 4 FUs push one result in the same cycle, `rr_ptr`=0.
  - Expected: broadcasts in FU order 0,1,2,3 over 4 consecutive cycles.
  - Then FUs 1 and 3 push again → order is 1,3, since `rr_ptr` is now 0 and FU0 is empty.
- **Full and back-pressure.**
  - DEPTH=2, FU0 offers 5 back-to-back results (1,2,3,4,5) while FU1 keeps its FIFO non-empty.
  - `fu_ready[0]` drops when count hits 2.
  - All five FU0 values appear on the CDB in order 1..5, each exactly once, with FU1's results interleaved as round-robin requires.
- **INVALID-tag drop.** FU1 asserts valid with tag INVALID, data 32'h5 → no push, `pending` unchanged, no ack, no broadcast.
- **FLUSH.**
  - Setup: `pending`=5, then assert FLUSH for 1 cycle concurrently with an FU3 push.
  - Next cycle: `pending`=0, `cdb_out.tag`=INVALID, no acks.
  - Subsequent cycles: no stale result is ever broadcast.
